window_gen: RTL and testbench

- Upstream feeder of the filter chain: turns a raster-order pixel stream (NCH channels per beat) into FN x FN sliding windows per channel, the x{k}_{j}_{i} operands the first filter layer consumes.
- Stride 1, no padding ("valid" convolution).
- Stores FN-1 image rows in line buffers plus an FN x FN window register per channel.
- Valid/ready handshake on both sides; one registered output stage.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/line_fifo.sv | 33 +++
 rtl/window_gen.sv | 172 +++++++++++++++++
 tb/tb_window_gen.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the CNN front end.
//   CNN_WIDTH    : default signed sample width
//   CNN_FN       : default kernel edge
//   win_elem_idx : flat element index of window element (k, j, i)
package cnn_pkg;

    localparam int unsigned CNN_WIDTH = 16;
    localparam int unsigned CNN_FN    = 3;

    // Element (channel k, row offset j, column offset i) of an FN x FN window.
    function automatic int unsigned win_elem_idx(input int unsigned k, input int unsigned j,
                                                 input int unsigned i, input int unsigned fn);
        return (k * fn + j) * fn + i;
    endfunction

endpackage

// File: rtl/line_fifo.sv
// One image-row delay line: a DEPTH-entry circular RAM with a shared read/write pointer.
// The read returns the sample written one row ago at the same column; on en the same
// location is overwritten with din.
//   clk  : clock
//   en   : write enable (pixel accepted)
//   ptr  : column pointer, owned by the parent
//   din  : sample to store
//   dout : sample stored DEPTH writes ago at ptr
module line_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 28,
    parameter int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             en,
    input  logic [PW-1:0]    ptr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // Not reset: a location is always written in the current frame before it is read
    // into an emitted window.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

    assign dout = mem[ptr];

endmodule

// File: rtl/window_gen.sv
// Sliding-window generator: turns a raster-order pixel stream (NCH channels per beat)
// into FN x FN stride-1 "valid" windows per channel.
//   clk, resetn : clock, asynchronous active-low reset
//   clear       : synchronous frame abort; wins over an accept, forces in_ready low
//   in_valid/in_ready/in_data : pixel beat input, channel k at [k*WIDTH +: WIDTH]
//   win_valid/win_ready       : window output handshake
//   win_data    : element (k,j,i) at win_elem_idx(k,j,i,FN)*WIDTH, j=0 oldest row
//   win_last    : marks the final window of a frame
module window_gen
    import cnn_pkg::*;
#(
    parameter int unsigned WIDTH = CNN_WIDTH,
    parameter int unsigned FN    = CNN_FN,
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28,
    parameter int unsigned NCH   = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NCH*WIDTH-1:0]        in_data,
    output logic                        win_valid,
    input  logic                        win_ready,
    output logic [NCH*FN*FN*WIDTH-1:0]  win_data,
    output logic                        win_last
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN = CW'(FN - 1);
    localparam logic [RW-1:0] ROW_MIN = RW'(FN - 1);

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [RW-1:0] row_q, row_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;

    logic accept;
    logic col_end, row_end, win_done;

    logic [WIDTH-1:0] lb_dout [NCH][FN-1];
    logic [WIDTH-1:0] new_col [NCH][FN];
    logic [WIDTH-1:0] win_q   [NCH][FN][FN];

    // Only output backpressure (and clear) can stall the input.
    assign in_ready = !clear && (!valid_q || win_ready);
    assign accept   = in_valid && in_ready;

    assign col_end  = (col_q == COL_MAX);
    assign row_end  = (row_q == ROW_MAX);
    // Earlier columns of a row only refill the window, so no window straddles rows.
    assign win_done = (row_q >= ROW_MIN) && (col_q >= COL_MIN);

    always_comb begin
        col_d   = col_q;
        ptr_d   = ptr_q;
        row_d   = row_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (clear) begin
            col_d   = '0;
            ptr_d   = '0;
            row_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (accept) begin
            col_d   = col_end ? '0 : col_q + CW'(1);
            ptr_d   = (ptr_q == COL_MAX) ? '0 : ptr_q + CW'(1);
            if (col_end) begin
                row_d = row_end ? '0 : row_q + RW'(1);
            end
            valid_d = win_done;
            last_d  = win_done && row_end && col_end;
        end else if (win_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_q   <= '0;
            ptr_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            ptr_q   <= ptr_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // Line buffers cascade: buffer 0 takes the pixel, buffer n takes buffer n-1's old value.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        for (genvar n = 0; n < FN - 1; n++) begin : g_lb
            logic [WIDTH-1:0] lb_din;
            if (n == 0) begin : g_head
                assign lb_din = in_data[k*WIDTH +: WIDTH];
            end else begin : g_tail
                assign lb_din = lb_dout[k][n-1];
            end
            line_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (IMG_W),
                .PW    (CW)
            ) u_line_fifo (
                .clk  (clk),
                .en   (accept),
                .ptr  (ptr_q),
                .din  (lb_din),
                .dout (lb_dout[k][n])
            );
        end
    end

    // Incoming column, oldest row first; the live pixel is the newest row.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            for (int j = 0; j < FN - 1; j++) begin
                new_col[k][j] = lb_dout[k][FN-2-j];
            end
            new_col[k][FN-1] = in_data[k*WIDTH +: WIDTH];
        end
    end

    // The window register doubles as the output stage: it only moves on accept, which
    // cannot happen while a window is held under backpressure.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NCH; k++) begin
                for (int j = 0; j < FN; j++) begin
                    for (int i = 0; i < FN; i++) begin
                        win_q[k][j][i] <= '0;
                    end
                end
            end
        end else if (accept) begin
            for (int k = 0; k < NCH; k++) begin
                for (int j = 0; j < FN; j++) begin
                    for (int i = 0; i < FN - 1; i++) begin
                        win_q[k][j][i] <= win_q[k][j][i+1];
                    end
                    win_q[k][j][FN-1] <= new_col[k][j];
                end
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < NCH; k++) begin
            for (int j = 0; j < FN; j++) begin
                for (int i = 0; i < FN; i++) begin
                    win_data[win_elem_idx(k, j, i, FN)*WIDTH +: WIDTH] = win_q[k][j][i];
                end
            end
        end
    end

    assign win_valid = valid_q;
    assign win_last  = last_q;

endmodule

// File: tb/tb_window_gen.sv
module tb_window_gen;

    localparam int WIDTH = 16;
    localparam int FN    = 3;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int NCH   = 1;
    localparam int WW    = NCH * FN * FN * WIDTH;

    // Hand-computed windows for pixel(r,c) = r*4 + c + 1, element (j,i) at (j*3+i)*16.
    localparam logic [WW-1:0] FIRST_WIN = {16'd11, 16'd10, 16'd9, 16'd7, 16'd6, 16'd5,
                                           16'd3, 16'd2, 16'd1};
    localparam logic [WW-1:0] LAST_WIN  = {16'd16, 16'd15, 16'd14, 16'd12, 16'd11, 16'd10,
                                           16'd8, 16'd7, 16'd6};

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic [NCH*WIDTH-1:0] in_data;
    logic                 win_valid;
    logic                 win_ready = 1'b1;
    logic [WW-1:0]        win_data;
    logic                 win_last;

    window_gen #(
        .WIDTH (WIDTH),
        .FN    (FN),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .NCH   (NCH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .win_last  (win_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_vec(input string name, input logic [WW-1:0] got,
                           input logic [WW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Image is captured as accepted; a window ending at (r,c) is the FN x FN block of the
    // image whose bottom-right corner is (r,c).
    logic [WIDTH-1:0] img [IMG_H][IMG_W];
    logic [WW-1:0]    exp_q[$];
    bit               exp_last_q[$];
    int               trig_q[$];
    int               mr, mc;
    bit               expect_valid;
    int               win_rx = 0;
    int               win_in_frame;
    int               stall_seen = 0;
    int               stall_req = 0;
    logic [WW-1:0]    first_win, last_win;

    function automatic logic [WW-1:0] window_at(input int r, input int c);
        logic [WW-1:0] v;
        v = '0;
        for (int j = 0; j < FN; j++) begin
            for (int i = 0; i < FN; i++) begin
                v[(j*FN+i)*WIDTH +: WIDTH] = img[r-FN+1+j][c-FN+1+i];
            end
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (!resetn) begin
            mr = 0;
            mc = 0;
            exp_q.delete();
            exp_last_q.delete();
            expect_valid = 0;
            win_in_frame = 0;
        end else begin
            if (expect_valid) begin
                chk_bit("window one cycle after completing pixel", win_valid, 1'b1);
                expect_valid = 0;
            end
            if (win_valid) begin
                chk_int("window pending in model while win_valid", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk_vec("win_data", win_data, exp_q[0]);
                    chk_bit("win_last", win_last, exp_last_q[0]);
                    if (win_ready) begin
                        if (win_in_frame == 0) first_win = win_data;
                        win_in_frame++;
                        if (exp_last_q[0]) begin
                            last_win = win_data;
                            win_in_frame = 0;
                        end
                        void'(exp_q.pop_front());
                        void'(exp_last_q.pop_front());
                        win_rx++;
                    end else begin
                        stall_seen++;
                    end
                end
            end
            if (clear) begin
                chk_bit("in_ready during clear", in_ready, 1'b0);
                mr = 0;
                mc = 0;
                exp_q.delete();
                exp_last_q.delete();
                expect_valid = 0;
                win_in_frame = 0;
            end else begin
                chk_bit("in_ready", in_ready, !win_valid || win_ready);
                if (in_valid && in_ready) begin
                    img[mr][mc] = in_data;
                    if (mr >= FN - 1 && mc >= FN - 1) begin
                        exp_q.push_back(window_at(mr, mc));
                        exp_last_q.push_back(mr == IMG_H - 1 && mc == IMG_W - 1);
                        trig_q.push_back(int'(in_data));
                        expect_valid = 1;
                    end
                    if (mc == IMG_W - 1) begin
                        mc = 0;
                        mr = (mr == IMG_H - 1) ? 0 : mr + 1;
                    end else begin
                        mc++;
                    end
                end
            end
        end
    end

    // Consumer: holds win_ready low for stall_req cycles of visible windows.
    always @(posedge clk) begin
        #1;
        if (stall_req > 0 && win_valid) begin
            win_ready = 1'b0;
            stall_req--;
        end else begin
            win_ready = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_pixels(input int first, input int last, input int gap);
        for (int p = first; p <= last; p++) begin
            int waited;
            bit acc;
            waited = 0;
            acc = 0;
            while (!acc) begin
                in_valid = ($urandom_range(0, 99) >= gap);
                in_data  = 16'(p);
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk);
                #1;
                waited++;
                if (!acc && waited > 200) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pixel %0d accept timeout: waited %0d cycles, limit 200",
                             p, waited);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_frame(input string tag, input int rx0);
        chk_int({tag, " window count"}, win_rx - rx0, 4);
        chk_vec({tag, " first window"}, first_win, FIRST_WIN);
        chk_vec({tag, " last window"}, last_win, LAST_WIN);
    endtask

    initial begin
        int rx0;
        resetn   = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        idle(2);
        chk_bit("reset win_valid", win_valid, 1'b0);
        chk_bit("reset win_last", win_last, 1'b0);
        chk_vec("reset win_data", win_data, '0);
        resetn = 1'b1;
        idle(1);

        // Continuous stream, always ready.
        rx0 = win_rx;
        trig_q.delete();
        drive_pixels(1, 16, 0);
        idle(3);
        check_frame("plain", rx0);
        chk_int("trigger count", trig_q.size(), 4);
        if (trig_q.size() == 4) begin
            chk_int("trigger pixel 0", trig_q[0], 11);
            chk_int("trigger pixel 1", trig_q[1], 12);
            chk_int("trigger pixel 2", trig_q[2], 15);
            chk_int("trigger pixel 3", trig_q[3], 16);
        end

        // Two frames back to back.
        rx0 = win_rx;
        drive_pixels(1, 16, 0);
        drive_pixels(1, 16, 0);
        idle(3);
        chk_int("back-to-back window count", win_rx - rx0, 8);
        chk_vec("second frame first window", first_win, FIRST_WIN);
        chk_vec("second frame last window", last_win, LAST_WIN);

        // Backpressure on the first window.
        rx0 = win_rx;
        stall_seen = 0;
        stall_req = 5;
        drive_pixels(1, 16, 0);
        idle(3);
        check_frame("stalled", rx0);
        chk_int("stall cycles observed", stall_seen, 5);

        // Random input gaps.
        rx0 = win_rx;
        drive_pixels(1, 16, 50);
        idle(3);
        check_frame("gappy", rx0);

        // Clear after pixel 10, with pixel 11 presented in the clear cycle.
        rx0 = win_rx;
        drive_pixels(1, 10, 0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd11;
        idle(1);
        clear    = 1'b0;
        in_valid = 1'b0;
        idle(3);
        chk_int("aborted frame window count", win_rx - rx0, 0);
        rx0 = win_rx;
        drive_pixels(1, 16, 0);
        idle(3);
        check_frame("after clear", rx0);

        // Asynchronous reset while a window is held.
        stall_req = 1000;
        drive_pixels(1, 11, 0);
        #2;
        chk_bit("win_valid before reset", win_valid, 1'b1);
        resetn = 1'b0;
        #1;
        chk_bit("async reset win_valid", win_valid, 1'b0);
        chk_bit("async reset win_last", win_last, 1'b0);
        chk_vec("async reset win_data", win_data, '0);
        stall_req = 0;
        @(posedge clk);
        #1;
        idle(1);
        resetn = 1'b1;
        idle(1);
        rx0 = win_rx;
        drive_pixels(1, 16, 0);
        idle(3);
        check_frame("after reset", rx0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected end of test before it");
        $fatal(1);
    end

endmodule
